// File: rtl/mul_rep_add_seq.sv
// rtl/mul_rep_add_seq.sv - sequential multiplier by repeated addition with valid/ready handshakes
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready is high only in IDLE)
//   a, b                operands, WIDTH bits
//   abort               synchronous cancel of the operation in flight
//   out_valid, out_ready product handshake
//   product             PW-bit result, held after the handshake
//   busy                high in RUN or DONE
//
// Optional feature: define MUL_SIGNED_EN to treat a/b as two's complement.
module mul_rep_add_seq #(
    parameter int WIDTH = 16,
    parameter int PW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    product,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state, state_next;

    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             accept;
    logic [PW-1:0]    result;

`ifdef MUL_SIGNED_EN
    logic neg;

    // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
    assign mag_a  = a[WIDTH-1] ? -a : a;
    assign mag_b  = b[WIDTH-1] ? -b : b;
    // -0 == 0 in two's complement, so a zero accumulator stays zero
    assign result = neg ? -acc : acc;
`else
    assign mag_a  = a;
    assign mag_b  = b;
    assign result = acc;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort outranks both completion in RUN and the output handshake in DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            addend    <= '0;
            count     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // the smaller magnitude sets the iteration count; ties keep a as addend
                        if (mag_a >= mag_b) begin
                            addend <= mag_a;
                            count  <= mag_b;
                        end else begin
                            addend <= mag_b;
                            count  <= mag_a;
                        end
                        acc <= '0;
`ifdef MUL_SIGNED_EN
                        neg <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    if (!abort) begin
                        if (count == '0) begin
                            product   <= result;
                            out_valid <= 1'b1;
                        end else begin
                            acc   <= acc + {{(PW-WIDTH){1'b0}}, addend};
                            count <= count - ONE;
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_rep_add_seq.sv
// tb/tb_mul_rep_add_seq.sv - directed self-checking bench for mul_rep_add_seq
module tb_mul_rep_add_seq;

    localparam int WIDTH = 16;
    localparam int PW    = 2 * WIDTH;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    product;
    logic             busy;

    int checks;
    int failures;

    mul_rep_add_seq #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operand pair for a single acceptance edge, then counts
    // cycles until out_valid is seen; lat = -1 when the budget expires.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input int budget, output int lat);
        @(negedge clk);
        a = ia;
        b = ib;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags: got in_ready/out_valid/busy=%b expected 100",
                     {in_ready, out_valid, busy});
        end
        checks++;
        if (product !== '0) begin
            failures++;
            $display("FAIL reset_product: got %h expected 0", product);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        run_op(16'd7, 16'd5, 20, lat);
        checks++;
        if (lat !== 6) begin
            failures++;
            $display("FAIL basic_latency: got %0d expected 6", lat);
        end
        checks++;
        if (product !== 32'd35) begin
            failures++;
            $display("FAIL basic_product: got %0d expected 35", product);
        end
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL basic_return_idle: got in_ready/out_valid/busy=%b expected 100",
                     {in_ready, out_valid, busy});
        end
        checks++;
        if (product !== 32'd35) begin
            failures++;
            $display("FAIL basic_product_held: got %0d expected 35", product);
        end
    endtask

    task automatic test_zero_then_small();
        int lat;
        out_ready = 1'b1;
        run_op(16'd0, 16'd1234, 20, lat);
        checks++;
        if (lat !== 1 || product !== 32'd0) begin
            failures++;
            $display("FAIL zero_operand: got latency %0d product %0d expected 1 and 0", lat, product);
        end
        @(negedge clk);
        run_op(16'd300, 16'd2, 20, lat);
        checks++;
        if (lat !== 3 || product !== 32'd600) begin
            failures++;
            $display("FAIL swap_300x2: got latency %0d product %0d expected 3 and 600", lat, product);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        logic bad;
        out_ready = 1'b0;
        run_op(16'd5, 16'd9, 30, lat);
        checks++;
        if (lat !== 6 || product !== 32'd45) begin
            failures++;
            $display("FAIL bp_result: got latency %0d product %0d expected 6 and 45", lat, product);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (product !== 32'd45 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: got unstable output while stalled, expected product 45 held with in_ready 0");
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL bp_release: got in_ready/out_valid/busy=%b expected 100",
                     {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_abort_run();
        logic seen;
        out_ready = 1'b1;
        @(negedge clk);
        a = 16'd100;
        b = 16'd50;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL abort_run_idle: got in_ready/out_valid/busy=%b expected 100",
                     {in_ready, out_valid, busy});
        end
        checks++;
        if (product !== 32'd45) begin
            failures++;
            $display("FAIL abort_run_product: got %0d expected 45", product);
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_run_no_output: got out_valid rising expected none");
        end
    endtask

    task automatic test_abort_done();
        int lat;
        out_ready = 1'b0;
        run_op(16'd3, 16'd2, 20, lat);
        checks++;
        if (lat !== 3 || product !== 32'd6) begin
            failures++;
            $display("FAIL abort_done_result: got latency %0d product %0d expected 3 and 6", lat, product);
        end
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== 32'd6) begin
            failures++;
            $display("FAIL abort_done: got flags %b product %0d expected 100 and 6",
                     {in_ready, out_valid, busy}, product);
        end
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        @(negedge clk);
        a = 16'd100;
        b = 16'd50;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== '0) begin
            failures++;
            $display("FAIL reset_mid_run: got flags %b product %h expected 100 and 0",
                     {in_ready, out_valid, busy}, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        out_ready = 1'b1;
        first = -1;
        second = -1;
        @(negedge clk);
        a = 16'd2;
        b = 16'd3;
        in_valid = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (first !== 4 || second !== 9) begin
            failures++;
            $display("FAIL back_to_back: got out_valid at %0d,%0d expected 4,9", first, second);
        end
        checks++;
        if (product !== 32'd6) begin
            failures++;
            $display("FAIL back_to_back_product: got %0d expected 6", product);
        end
        while (!in_ready) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_max();
        int lat;
        out_ready = 1'b1;
        run_op(16'hFFFF, 16'hFFFF, 70000, lat);
`ifdef MUL_SIGNED_EN
        checks++;
        if (lat !== 2 || product !== 32'd1) begin
            failures++;
            $display("FAIL max_operands: got latency %0d product %h expected 2 and 00000001", lat, product);
        end
`else
        checks++;
        if (lat !== 65536 || product !== 32'hFFFE0001) begin
            failures++;
            $display("FAIL max_operands: got latency %0d product %h expected 65536 and fffe0001", lat, product);
        end
`endif
        @(negedge clk);
    endtask

`ifdef MUL_SIGNED_EN
    task automatic test_signed();
        int lat;
        out_ready = 1'b1;
        run_op(16'hFFFD, 16'd5, 20, lat);
        checks++;
        if (lat !== 4 || product !== 32'hFFFFFFF1) begin
            failures++;
            $display("FAIL signed_neg3x5: got latency %0d product %h expected 4 and fffffff1", lat, product);
        end
        @(negedge clk);
        run_op(16'h8000, 16'hFFFF, 20, lat);
        checks++;
        if (lat !== 2 || product !== 32'h00008000) begin
            failures++;
            $display("FAIL signed_min_x_neg1: got latency %0d product %h expected 2 and 00008000", lat, product);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        test_reset();
        test_basic();
        test_zero_then_small();
        test_backpressure();
        test_abort_run();
        test_abort_done();
        test_reset_mid_run();
        test_back_to_back();
`ifdef MUL_SIGNED_EN
        test_signed();
`endif
        test_max();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
